tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Receive-side counterpart of the 4:1 word multiplexer.
- Accepts a time-division-multiplexed word stream, one word per slot, four slots per frame, with slot 0 marked by frame_sync.
- Steers each word into one of four registered output channels and pulses a per-channel valid strobe.
- Sits between the serialised datapath and the four consumer units; tracks frame alignment and flags sync errors.

Parameters:
- WIDTH, 4, data word width of in_data and of each output channel.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  incoming TDM word.
- in_valid  input  1  in_data is valid this cycle; the word is accepted on the clk rising edge.
- frame_sync  input  1  qualifies in_data as slot 0; only meaningful when in_valid=1.
- out1  output  WIDTH  channel 1 holding register (slot 0).
- out2  output  WIDTH  channel 2 holding register (slot 1).
- out3  output  WIDTH  channel 3 holding register (slot 2).
- out4  output  WIDTH  channel 4 holding register (slot 3).
- out_valid  output  4  one-hot strobe; bit k is high for one cycle when out(k+1) updates.
- frame_done  output  1  one-cycle pulse when slot 3 has been written.
- locked  output  1  high while frame-aligned.
- sync_err  output  1  frame alignment error indication.

Behaviour:
- Interface: one clock (clk); asynchronous active-low reset (rst_n). Reset is asserted asynchronously and takes effect immediately.
- Reset values: out1..out4=0, out_valid=0, frame_done=0, locked=0, sync_err=0, state=HUNT, slot=0.
- Reset mid-frame discards the partial frame; the four channels are not restored.
- State HUNT:
  - in_valid=1 and frame_sync=0: word dropped, no strobe.
  - in_valid=1 and frame_sync=1: out1<=in_data, out_valid<=0001, slot<=1, state<=LOCKED.
- State LOCKED, in_valid=1 and frame_sync=0:
  - Write channel slot+1 and set out_valid bit slot.
  - slot increments modulo 4 (3 wraps to 0).
  - frame_done pulses on the same edge as the slot-3 write.
- State LOCKED, in_valid=1 and frame_sync=1:
  - slot==0: normal slot-0 write.
  - slot!=0: sync_err asserts, the word is written to out1 as slot 0, and slot<=1. This is a resync; frame_done is not pulsed and state stays LOCKED.
- in_valid=0: no writes, all strobes 0, slot held. frame_sync alone is ignored.
- Latency: one cycle from accepting edge to out*/out_valid update.
- Channels not being written hold their value.
- Exactly one out_valid bit, or none, is high in any cycle.
- locked is the registered decode of state==LOCKED.
- sync_err is a one-cycle pulse (see Optional Feature).

Optional Feature:
- Macro: TDM_DEMUX_STICKY_ERR_EN.
- Defined: sync_err is sticky. It is set on the first misaligned frame_sync and cleared only by rst_n.
- Not defined: sync_err is a one-cycle pulse per misaligned frame_sync.
- Datapath behaviour is identical in both builds.

Decomposition:
- Package tdm_demux_pkg holds:
  - NUM_SLOTS=4 and SLOT_W=2.
  - State enum {HUNT, LOCKED}.
  - One-hot strobe constants CH1..CH4 = 4'b0001..4'b1000.
- One natural sub-module, tdm_slot_counter: 2-bit slot counter with load-to-1 on sync, increment-with-wrap on accept, and terminal-count output driving frame_done.
- The output registers and FSM stay in tdm_demux4.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 with in_valid=0 for 5 cycles -> all outputs 0, locked=0.
- Aligned frame: words 0001 (frame_sync=1), 0011, 0111, 1111 on consecutive cycles.
  -> out1..out4 = 0001/0011/0111/1111.
  -> out_valid = 0001, 0010, 0100, 1000 in turn.
  -> frame_done high only on the 4th update; locked=1 from the 1st update.
- Hunt drop: 1010, 0101 with frame_sync=0 before lock -> no out_valid, outputs stay 0, locked=0.
- Misalignment: after lock, send 2 words, then 1100 with frame_sync=1.
  -> sync_err pulses, out1=1100, the next word goes to out2, no frame_done.
  -> With TDM_DEMUX_STICKY_ERR_EN defined, sync_err stays 1.
- Gaps and wrap: two full frames with in_valid=0 gaps of 1–3 cycles between words.
  -> Slots advance only on valid words; slot 3 wraps to out1 on the next frame; frame_done pulses twice.
- Reset mid-frame: assert rst_n=0 asynchronously after slot 1.
  -> Outputs clear immediately, without waiting for a clk edge; locked=0; the next frame_sync word relocks to out1.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the 4-slot TDM word demultiplexer.
// Optional feature macro: TDM_DEMUX_STICKY_ERR_EN (used in tdm_demux4).
package tdm_demux_pkg;

   localparam int NUM_SLOTS = 4;
   localparam int SLOT_W    = 2;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [3:0] CH1 = 4'b0001;
   localparam logic [3:0] CH2 = 4'b0010;
   localparam logic [3:0] CH3 = 4'b0100;
   localparam logic [3:0] CH4 = 4'b1000;

   // Map a slot number onto its one-hot channel strobe.
   function automatic logic [3:0] slot_onehot(input logic [SLOT_W-1:0] slot);
      logic [3:0] strobe;
      case (slot)
         2'd0:    strobe = CH1;
         2'd1:    strobe = CH2;
         2'd2:    strobe = CH3;
         2'd3:    strobe = CH4;
         default: strobe = 4'b0000;
      endcase
      return strobe;
   endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot position tracker: loads 1 when a slot-0 word is taken, advances
// with wrap on every other accepted word, flags the last slot of a frame.
module tdm_slot_counter
   import tdm_demux_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              inc,
   output logic [SLOT_W-1:0] slot,
   output logic              tc
);

   logic [SLOT_W-1:0] slot_r;

   // Slot register: sync load has priority over increment, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_r <= 2'd0;
      end else if (load) begin
         slot_r <= 2'd1;
      end else if (inc) begin
         slot_r <= slot_r + 2'd1;
      end else begin
         slot_r <= slot_r;
      end
   end

   assign slot = slot_r;
   assign tc   = (slot_r == 2'd3);

endmodule

// File: rtl/tdm_demux4.sv
// 4-channel TDM word demultiplexer with frame alignment tracking.
// Optional feature macro: TDM_DEMUX_STICKY_ERR_EN -- when defined, sync_err
// latches on the first misaligned frame_sync until rst_n; otherwise it pulses.
module tdm_demux4
   import tdm_demux_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             frame_sync,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic [WIDTH-1:0] out4,
   output logic [3:0]       out_valid,
   output logic             frame_done,
   output logic             locked,
   output logic             sync_err
);

   state_t            state_r;
   logic [WIDTH-1:0]  out1_r, out2_r, out3_r, out4_r;
   logic [3:0]        out_valid_r;
   logic              frame_done_r, locked_r, sync_err_r;

   logic              sync_s, inc_s, misalign_s, tc_s;
   logic [SLOT_W-1:0] slot_s;

   // A slot-0 word only counts when it is actually accepted; mid-frame
   // words only advance the slot once aligned.
   assign sync_s     = in_valid & frame_sync;
   assign inc_s      = in_valid & ~frame_sync & (state_r == LOCKED);
   assign misalign_s = sync_s & (state_r == LOCKED) & (slot_s != 2'd0);

   tdm_slot_counter u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (sync_s),
      .inc   (inc_s),
      .slot  (slot_s),
      .tc    (tc_s)
   );

   // Alignment FSM, channel holding registers and status strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= HUNT;
         out1_r       <= '0;
         out2_r       <= '0;
         out3_r       <= '0;
         out4_r       <= '0;
         out_valid_r  <= 4'b0000;
         frame_done_r <= 1'b0;
         locked_r     <= 1'b0;
         sync_err_r   <= 1'b0;
      end else begin
         out_valid_r  <= 4'b0000;
         frame_done_r <= 1'b0;
`ifdef TDM_DEMUX_STICKY_ERR_EN
         sync_err_r   <= sync_err_r | misalign_s;
`else
         sync_err_r   <= misalign_s;
`endif
         case (state_r)
            HUNT: begin
               if (sync_s) begin
                  out1_r      <= in_data;
                  out_valid_r <= CH1;
                  state_r     <= LOCKED;
                  locked_r    <= 1'b1;
               end else begin
                  state_r     <= HUNT;
                  locked_r    <= 1'b0;
               end
            end
            LOCKED: begin
               state_r  <= LOCKED;
               locked_r <= 1'b1;
               if (sync_s) begin
                  // Normal slot 0 or resync: either way the word is slot 0.
                  out1_r      <= in_data;
                  out_valid_r <= CH1;
               end else if (inc_s) begin
                  out_valid_r  <= slot_onehot(slot_s);
                  frame_done_r <= tc_s;
                  case (slot_s)
                     2'd0:    out1_r <= in_data;
                     2'd1:    out2_r <= in_data;
                     2'd2:    out3_r <= in_data;
                     2'd3:    out4_r <= in_data;
                     default: out1_r <= out1_r;
                  endcase
               end else begin
                  out1_r <= out1_r;
               end
            end
            default: begin
               state_r  <= HUNT;
               locked_r <= 1'b0;
            end
         endcase
      end
   end

   assign out1       = out1_r;
   assign out2       = out2_r;
   assign out3       = out3_r;
   assign out4       = out4_r;
   assign out_valid  = out_valid_r;
   assign frame_done = frame_done_r;
   assign locked     = locked_r;
   assign sync_err   = sync_err_r;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: a frame-level model predicts every
// channel write; a negedge monitor pops and compares on each strobe and
// checks that quiet cycles hold state.
module tb_tdm_demux4;

   localparam int W  = 4;
   localparam int NS = 4;
`ifdef TDM_DEMUX_STICKY_ERR_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         frame_sync = 1'b0;
   logic [W-1:0] out1, out2, out3, out4;
   logic [3:0]   out_valid;
   logic         frame_done, locked, sync_err;

   tdm_demux4 #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .frame_sync (frame_sync),
      .out1       (out1),
      .out2       (out2),
      .out3       (out3),
      .out4       (out4),
      .out_valid  (out_valid),
      .frame_done (frame_done),
      .locked     (locked),
      .sync_err   (sync_err)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      int                 ch;
      logic [3:0][W-1:0]  outs;
      bit                 fd;
      bit                 err;
   } exp_t;

   exp_t q[$];
   int   n_pass = 0;
   int   n_total = 0;

   // frame-level reference model
   bit                m_locked;
   int                m_slot;
   logic [3:0][W-1:0] m_out;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_locked = 1'b0;
      m_slot   = 0;
      m_out    = '0;
   endtask

   task automatic model_word(input logic [W-1:0] d, input bit fs);
      exp_t r;
      if (fs) begin
         r.err    = m_locked && (m_slot != 0);
         m_out[0] = d;
         m_slot   = 1;
         m_locked = 1'b1;
         r.ch     = 0;
         r.fd     = 1'b0;
         r.outs   = m_out;
         q.push_back(r);
      end else if (m_locked) begin
         r.ch          = m_slot;
         m_out[m_slot] = d;
         r.fd          = (m_slot == NS - 1);
         r.err         = 1'b0;
         m_slot        = (m_slot + 1) % NS;
         r.outs        = m_out;
         q.push_back(r);
      end
   endtask

   task automatic drive(input bit v, input logic [W-1:0] d, input bit fs);
      @(posedge clk);
      #1;
      in_valid   = v;
      in_data    = d;
      frame_sync = fs;
      if (v) model_word(d, fs);
   endtask

   task automatic send(input logic [W-1:0] d, input bit fs);
      drive(1'b1, d, fs);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, W'($urandom), 1'($urandom));
   endtask

   // monitor: compare on strobes, verify hold/quiet behaviour otherwise
   logic [3:0][W-1:0] exp_o = '0;
   bit                exp_locked = 1'b0;
   bit                err_seen = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_o      = '0;
         exp_locked = 1'b0;
         err_seen   = 1'b0;
         check("reset_outs", {out1, out2, out3, out4}, 32'd0);
         check("reset_flags", {out_valid, frame_done, locked, sync_err}, 32'd0);
      end else if (out_valid != 4'b0000) begin
         if (q.size() == 0) begin
            check("spurious_strobe", {28'd0, out_valid}, 32'd0);
         end else begin
            exp_t r;
            r = q.pop_front();
            exp_o      = r.outs;
            exp_locked = 1'b1;
            err_seen   = err_seen | r.err;
            check("out_valid", {28'd0, out_valid}, {28'd0, 4'b0001 << r.ch});
            check("outs", {out1, out2, out3, out4}, {r.outs[0], r.outs[1], r.outs[2], r.outs[3]});
            check("frame_done", {31'd0, frame_done}, {31'd0, r.fd});
            check("locked", {31'd0, locked}, 32'd1);
            check("sync_err", {31'd0, sync_err}, {31'd0, STICKY ? err_seen : r.err});
         end
      end else begin
         check("hold_outs", {out1, out2, out3, out4}, {exp_o[0], exp_o[1], exp_o[2], exp_o[3]});
         check("quiet_fd", {31'd0, frame_done}, 32'd0);
         check("quiet_locked", {31'd0, locked}, {31'd0, exp_locked});
         check("quiet_err", {31'd0, sync_err}, {31'd0, STICKY ? err_seen : 1'b0});
      end
   end

   initial begin
      model_reset();
      // reset then idle
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(5);
      // words before lock are dropped
      send(4'b1010, 1'b0);
      send(4'b0101, 1'b0);
      idle(2);
      // aligned frame
      send(4'b0001, 1'b1);
      send(4'b0011, 1'b0);
      send(4'b0111, 1'b0);
      send(4'b1111, 1'b0);
      idle(2);
      // misaligned frame_sync after two words, then complete a frame
      send(4'b1001, 1'b1);
      send(4'b0010, 1'b0);
      send(4'b1100, 1'b1);
      send(4'b0110, 1'b0);
      send(4'b0100, 1'b0);
      send(4'b1011, 1'b0);
      idle(2);
      // two frames with gaps between words
      for (int f = 0; f < 2; f++) begin
         for (int s = 0; s < NS; s++) begin
            send(W'($urandom), s == 0);
            idle($urandom_range(1, 3));
         end
      end
      // asynchronous reset after slot 1
      send(4'b1000, 1'b1);
      send(4'b1101, 1'b0);
      idle(1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_outs", {out1, out2, out3, out4}, 32'd0);
      check("async_flags", {out_valid, frame_done, locked, sync_err}, 32'd0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      // relock
      send(4'b1110, 1'b1);
      send(4'b0001, 1'b0);
      send(4'b0011, 1'b0);
      send(4'b0101, 1'b0);
      idle(2);
      // random traffic
      repeat (400) begin
         if ($urandom_range(0, 3) != 0) send(W'($urandom), $urandom_range(0, 5) == 0);
         else drive(1'b0, W'($urandom), 1'($urandom));
      end
      idle(4);
      check("queue_drained", q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
